// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RISC-V M-extension multiply/divide unit (MUL..REMU).
// Latency: DATA_W+1 cycles start-to-done; 1 cycle for div-by-zero/overflow (and multiplies with RISCV_MDU_FAST_MUL_EN).
// Backpressure: one op at a time; start ignored while busy; flush aborts and discards the result.
module riscv_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic [DATA_W-1:0] r_mcand, w_mcand_nxt;  // multiplicand or divisor magnitude
  logic [PW-1:0]     r_prod, w_prod_nxt;    // mul: {acc, multiplier}; div: {rem, quotient}
  logic              r_neg, w_neg_nxt;
  logic [DATA_W-1:0] r_result, r_res_prev, w_res_nxt;

  localparam logic [DATA_W-1:0] ZERO    = '0;
  localparam logic [DATA_W-1:0] ONES    = '1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Operand decode: signedness, magnitudes and division special cases
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [DATA_W-1:0] w_a_mag, w_b_mag;
  logic              w_div0, w_ovf, w_special, w_accept;

  assign w_a_sgn   = (i_funct3 != 3'b011) && (i_funct3 != 3'b101) && (i_funct3 != 3'b111);
  assign w_b_sgn   = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                     (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
  assign w_a_neg   = w_a_sgn & i_op_a[DATA_W-1];
  assign w_b_neg   = w_b_sgn & i_op_b[DATA_W-1];
  assign w_a_mag   = w_a_neg ? -i_op_a : i_op_a;
  assign w_b_mag   = w_b_neg ? -i_op_b : i_op_b;
  assign w_div0    = i_funct3[2] && (i_op_b == ZERO);
  assign w_ovf     = i_funct3[2] && !i_funct3[0] && (i_op_a == MOST_NEG) && (i_op_b == ONES);
  assign w_special = w_div0 | w_ovf;
  assign w_accept  = (r_state == S_IDLE) && i_start && !i_flush;

`ifdef RISCV_MDU_FAST_MUL_EN
  logic [PW-1:0] w_fast;
  assign w_fast = {ZERO, w_a_mag} * {ZERO, w_b_mag};
`endif

  // One shift-add multiply step: add multiplicand when multiplier LSB set, then shift right
  logic [DATA_W:0] w_sum;
  logic [PW-1:0]   w_mul_step;
  assign w_sum      = {1'b0, r_prod[PW-1:DATA_W]} + (r_prod[0] ? {1'b0, r_mcand} : {1'b0, ZERO});
  assign w_mul_step = {w_sum, r_prod[DATA_W-1:1]};

  // One restoring divide step; the shifted-out remainder MSB forces a subtract
  logic              w_sh_carry, w_ge;
  logic [DATA_W-1:0] w_sh_rem, w_dif;
  logic [PW-1:0]     w_div_step;
  assign w_sh_carry = r_prod[PW-1];
  assign w_sh_rem   = {r_prod[PW-2:DATA_W], r_prod[DATA_W-1]};
  assign w_ge       = w_sh_carry || (w_sh_rem >= r_mcand);
  assign w_dif      = w_sh_rem - r_mcand;
  assign w_div_step = {(w_ge ? w_dif : w_sh_rem), r_prod[DATA_W-2:0], w_ge};

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) w_state_nxt = S_DONE;
`ifdef RISCV_MDU_FAST_MUL_EN
          else if (!i_funct3[2]) w_state_nxt = S_DONE;
`endif
          else w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (i_flush)                w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(1))   w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: done is suppressed when a flush lands in DONE
  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_DONE) && !i_flush;
  end

  // Datapath next values: load on accepted start, step once per CALC cycle
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_funct3_nxt = r_funct3;
    w_mcand_nxt  = r_mcand;
    w_prod_nxt   = r_prod;
    w_neg_nxt    = r_neg;
    if (w_accept) begin
      w_funct3_nxt = i_funct3;
      w_cnt_nxt    = CW'(DATA_W);
      w_mcand_nxt  = w_b_mag;
      w_neg_nxt    = (i_funct3[2] && i_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      if (w_div0) begin
        // special results are placed in the quotient/remainder half, unsigned
        w_neg_nxt  = 1'b0;
        w_prod_nxt = i_funct3[1] ? {i_op_a, ZERO} : {ZERO, ONES};
      end else if (w_ovf) begin
        w_neg_nxt  = 1'b0;
        w_prod_nxt = i_funct3[1] ? {ZERO, ZERO} : {ZERO, i_op_a};
      end else if (i_funct3[2]) begin
        w_prod_nxt = {ZERO, w_a_mag};
      end else begin
`ifdef RISCV_MDU_FAST_MUL_EN
        w_prod_nxt = w_fast;
`else
        w_prod_nxt = {ZERO, w_a_mag};
`endif
      end
    end else if (r_state == S_CALC) begin
      w_cnt_nxt  = r_cnt - CW'(1);
      w_prod_nxt = r_funct3[2] ? w_div_step : w_mul_step;
    end
  end

  // Final result selection with sign correction, from the values entering DONE
  logic [PW-1:0]     w_full;
  logic [DATA_W-1:0] w_hi;
  assign w_full = w_neg_nxt ? -w_prod_nxt : w_prod_nxt;
  assign w_hi   = w_prod_nxt[PW-1:DATA_W];

  always_comb begin
    w_res_nxt = w_full[DATA_W-1:0];
    if (w_funct3_nxt[2]) begin
      if (w_funct3_nxt[1]) w_res_nxt = w_neg_nxt ? -w_hi : w_hi;
      else                 w_res_nxt = w_full[DATA_W-1:0];
    end else if (w_funct3_nxt[1:0] != 2'b00) begin
      w_res_nxt = w_full[PW-1:DATA_W];
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_funct3 <= w_funct3_nxt;
      r_mcand  <= w_mcand_nxt;
      r_prod   <= w_prod_nxt;
      r_neg    <= w_neg_nxt;
    end
  end

  // Result register: updated on entry to DONE; rolled back if that DONE is flushed
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_result   <= '0;
      r_res_prev <= '0;
    end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      r_res_prev <= r_result;
      r_result   <= w_res_nxt;
    end else if ((r_state == S_DONE) && i_flush) begin
      r_result   <= r_res_prev;
    end
  end

  assign o_result = r_result;

endmodule

// File: doc/riscv_mdu.md
# riscv_mdu

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the `riscv` core. It sits beside the ALU in the execute stage and accepts one operation at a time under a start/busy/done handshake. `busy` stalls the pipeline and `flush` cancels an in-flight operation on a branch redirect.

## Interface
- `DATA_W`, 32: operand and result width; even, ≥ 8.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `flush`  in  1  abort the current operation; the result is discarded.
- `funct3`  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  DATA_W  rs1 operand.
- `op_b`  in  DATA_W  rs2 operand.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  DATA_W  operation result; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, `busy`=0, `done`=0, `result`=0, and clears the counter and all datapath registers.
- Start acceptance:
  - IDLE with `start`=1 and `flush`=0: latch `funct3`, the operand magnitudes and the result sign; load counter = DATA_W.
  - Then go to CALC, except for the division special cases below, which go directly to DONE.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats `op_a` as signed and `op_b` as unsigned.
  - MULHU/DIVU/REMU treat both operands as unsigned.
  - Compute on magnitudes, then negate at DONE if the sign flag is set.
- Multiply (iterative): 2·DATA_W-bit shift-add, one multiplier bit per CALC cycle.
  - MUL returns the low DATA_W bits of the product.
  - MULH/MULHSU/MULHU return the high DATA_W bits of the sign-corrected product.
- Divide: restoring division, one quotient bit per CALC cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Truncation is toward zero.
- Division special cases (resolved at start, no CALC phase):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow, `op_a` = most-negative value and `op_b` = −1: DIV → `op_a`; REM → 0.
- CALC decrements the counter each cycle. On counter = 1 → DONE.
- DONE: register `result`, assert `done` for one cycle, → IDLE.
- `start` while `busy`=1 is ignored; there is no queuing.
- `flush`=1 in CALC or DONE: → IDLE next cycle, `done` not asserted, `result` keeps its previous value.
- `flush` and `start` both high in IDLE: flush wins and the start is dropped.
- `reset` low mid-operation: return to the reset state on the next edge.

## Timing
- Start sampled at edge E0.
- Normal op: CALC spans cycles 1..DATA_W; `done` is high in cycle DATA_W+1 (33 cycles for DATA_W=32).
- Special-case division: `done` is high in cycle 1.
- `result` is valid on the same edge `done` rises and is stable until the next accepted start reaches DONE.
- Back-to-back: a new `start` may be asserted in the cycle after `done`, because the state is IDLE again.
- `busy` rises the cycle after an accepted start and falls the cycle after `done`.

## Configuration
- `RISCV_MDU_FAST_MUL_EN` defined:
  - The four multiply ops use a single combinational 2·DATA_W-bit product and skip CALC: IDLE → DONE, `done` in cycle 1.
  - Divide is unchanged.
- Macro undefined: multiplies use the iterative shift-add path with DATA_W+1 cycle latency.

## Test plan
- MUL, `op_a`=7, `op_b`=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB; `done` pulses exactly 33 cycles after start (1 cycle with FAST_MUL); `busy` is high for those cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned divide: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with `done` in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush and ignored start:
  - `flush` in CALC cycle 10 → `busy`=0 next cycle, no `done`, `result` unchanged.
  - A `start` pulse during CALC is ignored, with no extra `done`.
  - `start`+`flush` together in IDLE → stays IDLE.
- `reset`=0 in CALC cycle 5 → next edge `busy`=0, `done`=0, `result`=0; a subsequent MUL 3×4 → 12.
